// File: rtl/fetch_pc_controller_if.sv
// rtl/fetch_pc_controller_if.sv - instruction-memory and decode-side bus of the fetch PC controller
interface fetch_pc_controller_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [31:0]           imem_rdata;
    logic                  if_valid;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic [31:0]           if_instr;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_pc, if_instr
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_pc_controller.sv
// rtl/fetch_pc_controller.sv - program counter owner and single-outstanding instruction fetch sequencer
module fetch_pc_controller #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  trap_valid,
    input  logic [ADDR_WIDTH-1:0] trap_addr,
    input  logic                  stall,
    fetch_pc_controller_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic                  r_kill, w_kill_nxt;
    logic                  r_if_valid, w_if_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_if_pc, w_if_pc_nxt;
    logic [31:0]           r_if_instr, w_if_instr_nxt;
    logic                  w_redirect;
    logic [ADDR_WIDTH-1:0] w_target_raw;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_redirect   = redirect_valid | trap_valid;
    assign w_target_raw = trap_valid ? trap_addr : redirect_addr;
    assign w_target     = {w_target_raw[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_kill_nxt     = r_kill;
        w_if_valid_nxt = r_if_valid & stall;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = r_if_instr;

        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (bus.imem_gnt) begin
                    w_state_nxt = WAIT;
                    // The stale address was accepted, so its response must be dropped later
                    if (w_redirect) w_kill_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    w_state_nxt = REQ;
                    if (r_kill || w_redirect) begin
                        w_kill_nxt = 1'b0;
                    end else begin
                        w_if_valid_nxt = 1'b1;
                        w_if_pc_nxt    = r_pc;
                        w_if_instr_nxt = bus.imem_rdata;
                        w_pc_nxt       = r_pc + ADDR_WIDTH'(4);
                        // The new instruction fills the buffer; only refetch if decode drains it
                        if (stall) w_state_nxt = HOLD;
                    end
                end else if (w_redirect) begin
                    w_kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (!r_if_valid || !stall) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_redirect) begin
            w_pc_nxt       = w_target;
            w_if_valid_nxt = 1'b0;
            if (r_state == HOLD) w_state_nxt = REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_VECTOR;
            r_kill     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_kill     <= w_kill_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
        end
    end

    assign bus.imem_req  = (r_state == REQ);
    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_instr  = r_if_instr;
endmodule

// File: doc/fetch_pc_controller.md
Name: fetch_pc_controller

Overview:
Owns the program counter and sequences instruction fetch for the RISC-V core. It issues one-outstanding-request fetches to instruction memory and presents fetched instructions to decode through a one-entry output register with a stall handshake. It applies redirects from execute (branch/jump) and from the trap unit, with flush and kill of in-flight responses.

Parameters:
ADDR_WIDTH, 32, width of PC and instruction addresses
RESET_VECTOR, 32'h0000_1000, PC value loaded at reset

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-low reset; sampled on posedge clk, 0 = reset
redirect_valid  input  1  branch/jump taken in execute
redirect_addr  input  ADDR_WIDTH  branch/jump target
trap_valid  input  1  trap/exception entry
trap_addr  input  ADDR_WIDTH  trap vector target
stall  input  1  decode cannot accept; instruction held while 1
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_WIDTH  fetch address
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid, one per granted request, at least 1 cycle after gnt
imem_rdata  input  32  fetched instruction
if_valid  output  1  if_instr/if_pc valid to decode
if_pc  output  ADDR_WIDTH  PC of if_instr
if_instr  output  32  fetched instruction

Behaviour:
- Reset (rst=0 at posedge): pc=RESET_VECTOR, state=IDLE, kill=0, if_valid=0, if_pc=0, if_instr=0, imem_req=0. Reset overrides everything, including mid-transaction; a later rvalid for a pre-reset request is ignored (IDLE/REQ ignore rvalid).
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: next cycle -> REQ (first imem_req one cycle after reset release).
- REQ: imem_req=1, imem_addr=pc. gnt=1 -> WAIT. gnt=0 -> stay. imem_addr changes while gnt=0 only on a redirect.
- WAIT: imem_req=0. On rvalid with kill=0: if_instr<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4. Next state REQ if buffer free next cycle (!if_valid or !stall), else HOLD. On rvalid with kill=1: drop data, kill<=0, -> REQ.
- HOLD: imem_req=0. When if_valid && !stall -> REQ.
- Consume: if_valid && !stall clears if_valid unless a new instruction loads the same cycle. Back-to-back throughput: 1 instruction per 2 cycles minimum (REQ+gnt, WAIT+rvalid).
- Redirect: target = trap_addr if trap_valid, else redirect_addr (trap has priority). Low 2 bits of target forced to 0. Effect, same cycle: pc<=target; if_valid<=0 (flush, regardless of stall); any response loading that cycle is discarded.
  - REQ, gnt=0: stay REQ, next imem_addr=target.
  - REQ, gnt=1: old address accepted; -> WAIT with kill<=1.
  - WAIT, rvalid=0: kill<=1, stay WAIT.
  - WAIT, rvalid=1: response dropped, -> REQ.
  - HOLD/IDLE: -> REQ.
- Back-to-back redirects: last one wins; kill stays 1 until one response is dropped.
- pc+4 wraps modulo 2^ADDR_WIDTH.
- stall never blocks an outstanding request or its response; only the output register waits.
- No combinational path from imem_rdata/rvalid to if_* outputs. The imem_req/imem_addr outputs are state-decoded and registered-path only.

Test Plan:
- Reset release, imem gnt same cycle, rvalid next cycle, stall=0 -> imem_addr 0x1000, 0x1004, 0x1008; if_pc follows, one instruction every 2 cycles.
- stall=1 for 5 cycles after first instruction -> if_valid/if_instr/if_pc hold at 0x1000; no imem_req until stall drops; next request addr 0x1004.
- redirect_valid=1, addr 0x2002, in WAIT before rvalid -> that response dropped, if_valid=0; next imem_addr 0x2000; next if_pc 0x2000.
- trap_valid and redirect_valid same cycle (0x0100 vs 0x3000) -> next fetch 0x0100.
- Redirect in REQ coincident with gnt for 0x1008 -> response for 0x1008 never appears on if_*; following fetch is at the target.
- rst=0 asserted in WAIT, rvalid arrives during/after reset -> outputs zero, data ignored, first request after release at 0x1000; pc 0xFFFF_FFFC fetch then +4 wraps to 0x0000_0000.
